imem_boot_loader: RTL and testbench

//  Boot-time controller for the single-cycle core's instruction memory. Takes a byte stream

---
 rtl/imem_boot_loader.sv | 157 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_boot_loader: packs a byte-stream boot image into imem words, verifies
// its XOR checksum and releases the core from reset.   Revision: 1.0
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        wr_en_imem_o,
  output logic [31:0] wr_addr_imem_o,
  output logic [31:0] wr_instr_imem_o,
  output logic        cpu_reset_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int c_idx_w = $clog2(IMEM_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [15:0]          r_len;
  logic [c_idx_w-1:0]   r_word_idx;
  logic [1:0]           r_byte_idx;
  logic [7:0]           r_xor;
  logic [23:0]          r_buf;
  logic                 r_wr_en;
  logic [31:0]          r_wr_addr;
  logic [31:0]          r_wr_instr;

  logic                 w_xfer;
  logic                 w_start_ok;
  logic [15:0]          w_len_full;
  logic [31:0]          w_idx32;
  logic                 w_last_word;
  logic [31:0]          w_word_addr;

  assign w_xfer      = rx_valid_i & rx_ready_o;
  assign w_start_ok  = start_i & ((r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_ERR));
  assign w_len_full  = {rx_data_i, r_len[7:0]};
  assign w_idx32     = 32'(r_word_idx);
  assign w_last_word = ((w_idx32 + 32'd1) == 32'(r_len));
  assign w_word_addr = BASE_ADDR + (w_idx32 << 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    rx_ready_o   = 1'b0;
    cpu_reset_o  = 1'b1;
    done_o       = 1'b0;
    err_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next_state = S_LEN0;
      end
      S_LEN0: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) w_next_state = S_LEN1;
      end
      S_LEN1: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          if (32'(w_len_full) > 32'(IMEM_DEPTH)) w_next_state = S_ERR;
          else if (w_len_full == 16'd0)          w_next_state = S_CSUM;
          else                                   w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i && (r_byte_idx == 2'd3) && w_last_word) w_next_state = S_CSUM;
      end
      S_CSUM: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) w_next_state = (rx_data_i == r_xor) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        cpu_reset_o = 1'b0;
        done_o      = 1'b1;
        if (start_i) w_next_state = S_LEN0;
      end
      S_ERR: begin
        err_o = 1'b1;
        if (start_i) w_next_state = S_LEN0;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Word packing, checksum and the registered imem write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len      <= 16'd0;
      r_word_idx <= '0;
      r_byte_idx <= 2'd0;
      r_xor      <= 8'd0;
      r_buf      <= 24'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 32'd0;
      r_wr_instr <= 32'd0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start_ok) begin
        r_word_idx <= '0;
        r_byte_idx <= 2'd0;
        r_xor      <= 8'd0;
      end else if (w_xfer) begin
        case (r_state)
          S_LEN0: r_len[7:0]  <= rx_data_i;
          S_LEN1: r_len[15:8] <= rx_data_i;
          S_DATA: begin
            r_xor <= r_xor ^ rx_data_i;
            if (r_byte_idx == 2'd3) begin
              r_wr_en    <= 1'b1;
              r_wr_addr  <= w_word_addr;
              r_wr_instr <= {rx_data_i, r_buf};
              r_word_idx <= r_word_idx + 1'b1;
              r_byte_idx <= 2'd0;
            end else begin
              r_buf[8*r_byte_idx +: 8] <= rx_data_i;
              r_byte_idx               <= r_byte_idx + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en_imem_o    = r_wr_en;
  assign wr_addr_imem_o  = r_wr_addr;
  assign wr_instr_imem_o = r_wr_instr;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// Bench for imem_boot_loader: frame-level reference model with per-cycle compare
// plus literal checks on known frames.
module tb_imem_boot_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        wr_en_imem_o;
  logic [31:0] wr_addr_imem_o;
  logic [31:0] wr_instr_imem_o;
  logic        cpu_reset_o;
  logic        done_o;
  logic        err_o;

  imem_boot_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .rx_data_i       (rx_data_i),
    .rx_valid_i      (rx_valid_i),
    .rx_ready_o      (rx_ready_o),
    .wr_en_imem_o    (wr_en_imem_o),
    .wr_addr_imem_o  (wr_addr_imem_o),
    .wr_instr_imem_o (wr_instr_imem_o),
    .cpu_reset_o     (cpu_reset_o),
    .done_o          (done_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the loader's state is derived from the bytes received so far.
  typedef enum int {P_IDLE, P_LOAD, P_RUN, P_ERR} phase_t;
  phase_t      m_phase;
  logic [7:0]  m_rx[$];
  bit          m_pulse;
  logic [31:0] m_addr, m_instr;
  logic [31:0] cap_addr[$], cap_data[$];
  logic [7:0]  tx[$];

  function automatic int frame_len();
    return int'(m_rx[0]) | (int'(m_rx[1]) << 8);
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_rx.delete();
    m_pulse = 1'b0;
    m_addr  = 32'd0;
    m_instr = 32'd0;
  endtask

  task automatic model_step(input bit st, input bit vld, input logic [7:0] d);
    bit         xfer;
    int         n, len, w;
    logic [7:0] x;
    xfer    = vld && (m_phase == P_LOAD);
    m_pulse = 1'b0;
    if (st && m_phase != P_LOAD) begin
      m_phase = P_LOAD;
      m_rx.delete();
    end else if (xfer) begin
      m_rx.push_back(d);
      n   = m_rx.size();
      len = (n >= 2) ? frame_len() : 0;
      if (n == 2 && len > DEPTH) begin
        m_phase = P_ERR;
      end else if (n > 2 && n <= 2 + 4*len && (n - 2) % 4 == 0) begin
        w       = (n - 2) / 4 - 1;
        m_pulse = 1'b1;
        m_addr  = BASE + 32'(4*w);
        m_instr = {m_rx[n-1], m_rx[n-2], m_rx[n-3], m_rx[n-4]};
      end else if (n == 3 + 4*len) begin
        x = 8'd0;
        for (int i = 2; i < 2 + 4*len; i++) x ^= m_rx[i];
        m_phase = (d == x) ? P_RUN : P_ERR;
      end
    end
  endtask

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (!reset) model_reset();
    else        model_step(start_i, rx_valid_i, rx_data_i);
    #1;
    if (wr_en_imem_o === 1'b1) begin
      cap_addr.push_back(wr_addr_imem_o);
      cap_data.push_back(wr_instr_imem_o);
    end
    chk("rx_ready",  32'(rx_ready_o),   32'(m_phase == P_LOAD));
    chk("cpu_reset", 32'(cpu_reset_o),  32'(m_phase != P_RUN));
    chk("done",      32'(done_o),       32'(m_phase == P_RUN));
    chk("err",       32'(err_o),        32'(m_phase == P_ERR));
    chk("wr_en",     32'(wr_en_imem_o), 32'(m_pulse));
    chk("wr_addr",   wr_addr_imem_o,    m_addr);
    chk("wr_instr",  wr_instr_imem_o,   m_instr);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start pulse with a byte offered while not ready; it must not be consumed.
  task automatic do_start();
    @(negedge clk);
    start_i    = 1'b1;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hAA;
    @(negedge clk);
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int gap_pct, input bit start_noise);
    int waitc;
    for (int i = 0; i < tx.size(); i++) begin
      waitc = 0;
      forever begin
        @(negedge clk);
        start_i = start_noise && (i >= 2) && (i < tx.size() - 1) && ($urandom_range(0, 99) < 20);
        if ($urandom_range(0, 99) < gap_pct) begin
          rx_valid_i = 1'b0;
          rx_data_i  = 8'($urandom);
        end else begin
          rx_valid_i = 1'b1;
          rx_data_i  = tx[i];
          if (rx_ready_o) break;
        end
        waitc++;
        if (waitc > 200) begin
          chk("rx_timeout", 32'd0, 32'd1);
          rx_valid_i = 1'b0;
          start_i    = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    rx_valid_i = 1'b0;
    start_i    = 1'b0;
  endtask

  task automatic make_frame(input int len, input bit bad);
    logic [7:0] x, b;
    tx.delete();
    tx.push_back(8'(len));
    tx.push_back(8'(len >> 8));
    x = 8'd0;
    for (int i = 0; i < 4*len; i++) begin
      b = 8'($urandom);
      tx.push_back(b);
      x ^= b;
    end
    tx.push_back(bad ? (x ^ 8'h5A) : x);
  endtask

  task automatic check_t1_writes(input string tag, input int base);
    chk({tag, "_nwr"},   32'(cap_addr.size() - base), 32'd2);
    chk({tag, "_addr0"}, cap_addr[base],   32'h0000_0000);
    chk({tag, "_data0"}, cap_data[base],   32'h2008_0013);
    chk({tag, "_addr1"}, cap_addr[base+1], 32'h0000_0004);
    chk({tag, "_data1"}, cap_data[base+1], 32'h2009_0004);
  endtask

  int base;
  bit bad;

  initial begin
    model_reset();
    reset      = 1'b0;
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'd0;
    idle(2);
    chk("rst_ready",     32'(rx_ready_o),   32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset_o),  32'd1);
    chk("rst_wr_en",     32'(wr_en_imem_o), 32'd0);
    chk("rst_done",      32'(done_o),       32'd0);
    chk("rst_err",       32'(err_o),        32'd0);
    reset = 1'b1;
    idle(2);

    // Known two-word image; the XOR of its payload bytes is 0x16.
    base = cap_addr.size();
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00, 8'h09, 8'h20, 8'h16};
    do_start();
    send_frame(0, 1'b0);
    idle(2);
    check_t1_writes("t1", base);
    chk("t1_done",      32'(done_o),      32'd1);
    chk("t1_cpu_reset", 32'(cpu_reset_o), 32'd0);

    // Same image with a wrong checksum.
    base = cap_addr.size();
    tx[10] = 8'h19;
    do_start();
    send_frame(0, 1'b0);
    idle(2);
    chk("t2_err",       32'(err_o),       32'd1);
    chk("t2_done",      32'(done_o),      32'd0);
    chk("t2_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("t2_nwr",       32'(cap_addr.size() - base), 32'd2);

    // Oversized length rejected right after LEN_HI, then maximum length accepted.
    base = cap_addr.size();
    tx = '{8'h01, 8'h01};
    do_start();
    send_frame(0, 1'b0);
    idle(2);
    chk("t3_err", 32'(err_o), 32'd1);
    chk("t3_nwr", 32'(cap_addr.size() - base), 32'd0);
    make_frame(DEPTH, 1'b0);
    do_start();
    send_frame(0, 1'b0);
    idle(2);
    chk("t3_max_nwr",   32'(cap_addr.size() - base), 32'(DEPTH));
    chk("t3_max_last",  cap_addr[cap_addr.size()-1], 32'h0000_03FC);
    chk("t3_max_done",  32'(done_o), 32'd1);

    // Empty images.
    base = cap_addr.size();
    tx = '{8'h00, 8'h00, 8'h00};
    do_start();
    send_frame(0, 1'b0);
    idle(2);
    chk("t4_done0", 32'(done_o), 32'd1);
    tx = '{8'h00, 8'h00, 8'h01};
    do_start();
    send_frame(0, 1'b0);
    idle(2);
    chk("t4_err1", 32'(err_o), 32'd1);
    chk("t4_nwr",  32'(cap_addr.size() - base), 32'd0);

    // Valid gaps and start pulses mid-load.
    base = cap_addr.size();
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00, 8'h09, 8'h20, 8'h16};
    do_start();
    send_frame(40, 1'b1);
    idle(2);
    check_t1_writes("t5", base);
    chk("t5_done", 32'(done_o), 32'd1);
    for (int k = 0; k < 6; k++) begin
      bad = 1'($urandom_range(0, 1));
      make_frame($urandom_range(1, 8), bad);
      do_start();
      send_frame(30, 1'b1);
      idle(2);
      chk("t5_rand_done", 32'(done_o), 32'(!bad));
    end

    // Restart from RUN raises the core reset on the next edge.
    make_frame(3, 1'b0);
    do_start();
    send_frame(0, 1'b0);
    idle(1);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("t6_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("t6_done",      32'(done_o),      32'd0);
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00, 8'h09, 8'h20, 8'h16};
    base = cap_addr.size();
    send_frame(0, 1'b0);
    idle(2);
    check_t1_writes("t6", base);
    chk("t6_reload_done", 32'(done_o), 32'd1);

    // Asynchronous reset in the middle of the payload.
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08};
    do_start();
    send_frame(0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_arst_ready",     32'(rx_ready_o),   32'd0);
    chk("t6_arst_cpu_reset", 32'(cpu_reset_o),  32'd1);
    chk("t6_arst_addr",      wr_addr_imem_o,    32'd0);
    chk("t6_arst_instr",     wr_instr_imem_o,   32'd0);
    chk("t6_arst_done",      32'(done_o),       32'd0);
    idle(2);
    reset = 1'b1;
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00, 8'h09, 8'h20, 8'h16};
    base = cap_addr.size();
    do_start();
    send_frame(20, 1'b0);
    idle(2);
    check_t1_writes("t6_post", base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
